sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/arm_mem_pkg.sv | 21 ++
 rtl/sram_wait_counter.sv | 26 ++
 rtl/sram_controller.sv | 110 +++++++++++
 tb/tb_sram_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the CPU-to-16-bit-SRAM bridge.
// A 32-bit word is carried as two halfword phases.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } mem_state_t;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;
  localparam int HALF_W = 16;
  localparam int CNT_W  = 4;

  // Word index relative to the SRAM base; the subtraction wraps modulo 2^32.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Phase counter: counts 0..WAIT_CYCLES-1 while enabled and wraps to 0 after
// the terminal count. Clear has priority over enable.
module sram_wait_counter
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  assign terminal = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (clear)    cnt <= '0;
    else if (enable)   cnt <= terminal ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/sram_controller.sv
// Stalling bridge from the MEM stage to an asynchronous 16-bit SRAM. Each
// 32-bit access becomes a low-halfword phase followed by a high-halfword phase.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HALF_W-1:0]  sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [HALF_W-1:0]  sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t       state, state_next;
  logic             op_write;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_data;
  logic [CNT_W-1:0] cnt;
  logic             terminal;
  logic             req;
  logic             start;
  logic             in_phase;

  assign req      = wr_en | rd_en;
  assign start    = (state == ST_IDLE) && req;
  assign in_phase = (state == ST_LOW) || (state == ST_HIGH);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_phase),
    .enable  (in_phase),
    .cnt     (cnt),
    .terminal(terminal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req)      state_next = ST_LOW;
      ST_LOW:  if (terminal) state_next = ST_HIGH;
      ST_HIGH: if (terminal) state_next = ST_DONE;
      ST_DONE:               state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  // Request is captured once; the pipeline may change its inputs while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_write <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (start) begin
      op_write <= wr_en;
      lat_addr <= address;
      lat_data <= write_data;
    end
  end

  // Loaded on entry to each phase so the address is stable for the whole phase
  // and holds once the access ends. Upper word bits are truncated away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr <= '0;
    end else if (start) begin
      sram_addr <= SRAM_AW'({word_index(address, ADDR_BASE), 1'b0});
    end else if ((state == ST_LOW) && terminal) begin
      sram_addr <= SRAM_AW'({word_index(lat_addr, ADDR_BASE), 1'b1});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if (in_phase && !op_write && terminal) begin
      if (state == ST_LOW) read_data[15:0]  <= sram_dq_in;
      else                 read_data[31:16] <= sram_dq_in;
    end
  end

  assign ready       = ((state == ST_IDLE) && !req) || (state == ST_DONE);
  assign sram_dq_oe  = in_phase && op_write;
  assign sram_dq_out = (state == ST_HIGH) ? lat_data[31:16] : lat_data[15:0];
  // The strobe rises one cycle before the phase ends to give data hold time.
  assign sram_we_n   = !(in_phase && op_write && (cnt < LAST));
  assign sram_oe_n   = !(in_phase && !op_write);

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: stimulus queues expected transactions,
// a negedge monitor measures each stall and compares at the DONE cycle.
module tb_sram_controller;

  typedef struct {
    bit          wr;
    logic [31:0] rd;
    logic [17:0] a0;
    logic [17:0] a1;
    logic [15:0] d0;
    logic [15:0] d1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_oe_n;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  // SRAM model: 16 locations decoded from the low address bits.
  logic [15:0] mem [0:15] = '{16'h1111, 16'h2222, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h5678, 16'h1234};
  assign sram_dq_in = mem[sram_addr[3:0]];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] <= sram_dq_out;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(bit wr, logic [31:0] rd, logic [17:0] a0, logic [17:0] a1,
                              logic [15:0] d0, logic [15:0] d1);
    exp_t e;
    e.wr = wr; e.rd = rd; e.a0 = a0; e.a1 = a1; e.d0 = d0; e.d1 = d1;
    return e;
  endfunction

  // Monitor: lo_n==1 is the IDLE request cycle, 2 is LOW cnt0, 6 is HIGH cnt0.
  int          lo_n = 0;
  int          we_cnt = 0;
  int          oe_cnt = 0;
  logic [17:0] a0_s, a1_s;
  logic [15:0] d0_s, d1_s;
  exp_t        me;

  always @(negedge clk) begin
    if (!rst) begin
      lo_n = 0; we_cnt = 0; oe_cnt = 0;
    end else if (!ready) begin
      lo_n++;
      if (!sram_we_n) we_cnt++;
      if (!sram_oe_n) oe_cnt++;
      if (lo_n == 2) begin a0_s = sram_addr; d0_s = sram_dq_out; end
      if (lo_n == 6) begin a1_s = sram_addr; d1_s = sram_dq_out; end
    end else if (lo_n > 0) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got stall of %0d cycles want none", lo_n);
      end else begin
        me = q.pop_front();
        chk("stall_len", 32'(lo_n), 32'd9);
        chk("read_data", read_data, me.rd);
        chk("addr_low", {14'd0, a0_s}, {14'd0, me.a0});
        chk("addr_high", {14'd0, a1_s}, {14'd0, me.a1});
        if (me.wr) begin
          chk("dq_low", {16'd0, d0_s}, {16'd0, me.d0});
          chk("dq_high", {16'd0, d1_s}, {16'd0, me.d1});
          chk("we_cycles", 32'(we_cnt), 32'd6);
          chk("oe_cycles_wr", 32'(oe_cnt), 32'd0);
        end else begin
          chk("oe_cycles", 32'(oe_cnt), 32'd8);
          chk("we_cycles_rd", 32'(we_cnt), 32'd0);
        end
      end
      lo_n = 0; we_cnt = 0; oe_cnt = 0;
    end
  end

  task automatic wait_done(string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 40);
    if (!ready) begin
      total++; bad++;
      $display("FAIL %s_timeout: got ready=%b want 1", nm, ready);
    end
  endtask

  // Inputs are scrambled once the request is latched to show they are ignored.
  task automatic access(string nm, bit w, bit r, logic [31:0] a, logic [31:0] d, exp_t e);
    q.push_back(e);
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; address = 32'h5555_0000; write_data = 32'hFFFF_FFFF;
    wait_done(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    rst = 1'b1;

    access("wr1028", 1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF,
           mk(1'b1, 32'h0, 18'd2, 18'd3, 16'hBEEF, 16'hDEAD));
    access("rd1028", 1'b0, 1'b1, 32'd1028, 32'h0,
           mk(1'b0, 32'hDEAD_BEEF, 18'd2, 18'd3, 16'h0, 16'h0));
    access("both1032", 1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D,
           mk(1'b1, 32'hDEAD_BEEF, 18'd4, 18'd5, 16'hF00D, 16'h0BAD));

    // Back-to-back reads with the request held through the stall.
    q.push_back(mk(1'b0, 32'h2222_1111, 18'd0, 18'd1, 16'h0, 16'h0));
    q.push_back(mk(1'b0, 32'h0BAD_F00D, 18'd4, 18'd5, 16'h0, 16'h0));
    @(posedge clk); #1;
    rd_en = 1'b1; address = 32'd1024;
    wait_done("b2b_first");
    address = 32'd1032;
    wait_done("b2b_second");
    rd_en = 1'b0;

    access("rd1020", 1'b0, 1'b1, 32'd1020, 32'h0,
           mk(1'b0, 32'h1234_5678, 18'h3FFFE, 18'h3FFFF, 16'h0, 16'h0));
    access("wr1020", 1'b1, 1'b0, 32'd1020, 32'hA5A5_5A5A,
           mk(1'b1, 32'h1234_5678, 18'h3FFFE, 18'h3FFFF, 16'h5A5A, 16'hA5A5));
    access("rd1020b", 1'b0, 1'b1, 32'd1020, 32'h0,
           mk(1'b0, 32'hA5A5_5A5A, 18'h3FFFE, 18'h3FFFF, 16'h0, 16'h0));

    // Abort a write at HIGH cnt=1: six edges after the request is presented.
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1028; write_data = 32'h7777_6666;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_pre_we_n", {31'd0, sram_we_n}, 32'd0);
    chk("abort_pre_addr", {14'd0, sram_addr}, 32'd3);
    rst = 1'b0; wr_en = 1'b0;
    #1;
    chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_sram_addr", {14'd0, sram_addr}, 32'd0);

    access("rd1024_post", 1'b0, 1'b1, 32'd1024, 32'h0,
           mk(1'b0, 32'h2222_1111, 18'd0, 18'd1, 16'h0, 16'h0));

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
